// File: rtl/dm_arbiter.sv
// ============================================================================
// Module   : dm_arbiter
// Purpose  : Two-port (A/B) arbiter in front of a single-ported data memory.
//            An access is sampled in IDLE and presented on the registered
//            mem_* bus for one ACCESS cycle; reads spend one extra RDATA
//            cycle to capture mem_read_data into the requester's rdata.
//            Ties between A and B are broken round-robin using a 1-bit
//            last-served pointer.
// Config   : define DM_ARB_FIXED_PRIO_EN to make port A always win ties
//            (the last-served pointer is then removed entirely).
// Ports    : clock, reset                    - clock, sync active-high reset
//            req_*, we_*, addr_*, wdata_*    - requester A/B access fields
//            gnt_*                           - one-cycle grant pulse
//            rvalid_*, rdata_*               - read completion / held data
//            mem_address, mem_write_data,
//            mem_write, mem_read             - registered memory bus
//            mem_read_data                   - memory data, valid the cycle
//                                              after mem_read
//            busy                            - high when not IDLE
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module dm_arbiter #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              req_a,
    input  logic              req_b,
    input  logic              we_a,
    input  logic              we_b,
    input  logic [ADDR_W-1:0] addr_a,
    input  logic [ADDR_W-1:0] addr_b,
    input  logic [DATA_W-1:0] wdata_a,
    input  logic [DATA_W-1:0] wdata_b,
    output logic              gnt_a,
    output logic              gnt_b,
    output logic              rvalid_a,
    output logic              rvalid_b,
    output logic [DATA_W-1:0] rdata_a,
    output logic [DATA_W-1:0] rdata_b,
    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_write_data,
    output logic              mem_write,
    output logic              mem_read,
    input  logic [DATA_W-1:0] mem_read_data,
    output logic              busy
);

    localparam logic [1:0] c_S_IDLE   = 2'd0;
    localparam logic [1:0] c_S_ACCESS = 2'd1;
    localparam logic [1:0] c_S_RDATA  = 2'd2;

    logic [1:0]        r_state;
    logic [1:0]        w_next_state;
    logic              w_any_req;
    logic              w_pick_b;
    logic              w_sel_we;
    logic              r_sel_b;
    logic              r_rvalid_a;
    logic              r_rvalid_b;
    logic [DATA_W-1:0] r_rdata_a;
    logic [DATA_W-1:0] r_rdata_b;
    logic [ADDR_W-1:0] r_mem_address;
    logic [DATA_W-1:0] r_mem_write_data;
    logic              r_mem_write;
    logic              r_mem_read;

    assign w_any_req = req_a | req_b;

`ifdef DM_ARB_FIXED_PRIO_EN
    // A always wins; B is only picked when it is the sole requester.
    assign w_pick_b = req_b & ~req_a;
`else
    // 1 = port B was served last, so A wins the next tie (reset value).
    logic r_last_b;

    assign w_pick_b = req_b & (~req_a | ~r_last_b);

    always_ff @(posedge clock) begin
        if (reset) begin
            r_last_b <= 1'b1;
        end else if (r_state == c_S_IDLE && w_any_req) begin
            r_last_b <= w_pick_b;
        end
    end
`endif

    assign w_sel_we = w_pick_b ? we_b : we_a;

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= c_S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_S_IDLE: begin
                if (w_any_req) begin
                    w_next_state = c_S_ACCESS;
                end
            end
            c_S_ACCESS: begin
                // The registered strobe tells us whether this access is a read.
                w_next_state = r_mem_read ? c_S_RDATA : c_S_IDLE;
            end
            c_S_RDATA: begin
                w_next_state = c_S_IDLE;
            end
            default: begin
                w_next_state = c_S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: state-decoded outputs
    // ------------------------------------------------------------------
    always_comb begin
        gnt_a = 1'b0;
        gnt_b = 1'b0;
        busy  = (r_state != c_S_IDLE);
        if (r_state == c_S_ACCESS) begin
            gnt_a = ~r_sel_b;
            gnt_b = r_sel_b;
        end
    end

    // ------------------------------------------------------------------
    // Datapath registers. The requester's fields are copied onto the
    // memory bus at the IDLE->ACCESS edge, so later changes by the
    // requester cannot disturb the in-flight access.
    // ------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (reset) begin
            r_sel_b          <= 1'b0;
            r_rvalid_a       <= 1'b0;
            r_rvalid_b       <= 1'b0;
            r_rdata_a        <= '0;
            r_rdata_b        <= '0;
            r_mem_address    <= '0;
            r_mem_write_data <= '0;
            r_mem_write      <= 1'b0;
            r_mem_read       <= 1'b0;
        end else begin
            // Strobes and read-valid pulses are single-cycle by default.
            r_rvalid_a  <= 1'b0;
            r_rvalid_b  <= 1'b0;
            r_mem_write <= 1'b0;
            r_mem_read  <= 1'b0;
            case (r_state)
                c_S_IDLE: begin
                    if (w_any_req) begin
                        r_sel_b          <= w_pick_b;
                        r_mem_address    <= w_pick_b ? addr_b : addr_a;
                        r_mem_write_data <= w_pick_b ? wdata_b : wdata_a;
                        r_mem_write      <= w_sel_we;
                        r_mem_read       <= ~w_sel_we;
                    end
                end
                c_S_RDATA: begin
                    if (r_sel_b) begin
                        r_rdata_b  <= mem_read_data;
                        r_rvalid_b <= 1'b1;
                    end else begin
                        r_rdata_a  <= mem_read_data;
                        r_rvalid_a <= 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign rvalid_a       = r_rvalid_a;
    assign rvalid_b       = r_rvalid_b;
    assign rdata_a        = r_rdata_a;
    assign rdata_b        = r_rdata_b;
    assign mem_address    = r_mem_address;
    assign mem_write_data = r_mem_write_data;
    assign mem_write      = r_mem_write;
    assign mem_read       = r_mem_read;

endmodule

`default_nettype wire

// File: tb/tb_dm_arbiter.sv
// ============================================================================
// Module   : tb_dm_arbiter
// Purpose  : Directed self-checking bench for dm_arbiter with a small
//            registered-read data memory model (location 0 holds 0xFF).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_dm_arbiter;

    logic       clock = 1'b0;
    logic       reset;
    logic       req_a, req_b, we_a, we_b;
    logic [7:0] addr_a, addr_b, wdata_a, wdata_b;
    logic       gnt_a, gnt_b, rvalid_a, rvalid_b;
    logic [7:0] rdata_a, rdata_b;
    logic [7:0] mem_address, mem_write_data;
    logic       mem_write, mem_read;
    logic [7:0] mem_read_data;
    logic       busy;
    logic       mem_init;

    int n_vec = 0;
    int n_err = 0;

    logic [7:0] mem [0:255];

    always #5 clock = ~clock;

    dm_arbiter #(.ADDR_W(8), .DATA_W(8)) dut (
        .clock          (clock),
        .reset          (reset),
        .req_a          (req_a),
        .req_b          (req_b),
        .we_a           (we_a),
        .we_b           (we_b),
        .addr_a         (addr_a),
        .addr_b         (addr_b),
        .wdata_a        (wdata_a),
        .wdata_b        (wdata_b),
        .gnt_a          (gnt_a),
        .gnt_b          (gnt_b),
        .rvalid_a       (rvalid_a),
        .rvalid_b       (rvalid_b),
        .rdata_a        (rdata_a),
        .rdata_b        (rdata_b),
        .mem_address    (mem_address),
        .mem_write_data (mem_write_data),
        .mem_write      (mem_write),
        .mem_read       (mem_read),
        .mem_read_data  (mem_read_data),
        .busy           (busy)
    );

    // Data memory: synchronous write, read data valid the cycle after mem_read.
    always @(posedge clock) begin
        if (mem_init) begin
            for (int i = 0; i < 256; i++) mem[i] <= 8'h00;
            mem[0]        <= 8'hFF;
            mem_read_data <= 8'h00;
        end else begin
            if (mem_write) mem[mem_address] <= mem_write_data;
            if (mem_read)  mem_read_data    <= mem[mem_address];
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one cycle, sample 1 time unit after the edge, and check the
    // exclusivity invariants every cycle.
    task automatic tick();
        @(posedge clock);
        #1;
        chk("excl_gnt", {31'd0, gnt_a & gnt_b}, 32'd0);
        chk("excl_strobe", {31'd0, mem_write & mem_read}, 32'd0);
    endtask

    // One complete access by a single port (p=0: A, p=1: B).
    task automatic xfer(input bit p, input bit we, input logic [7:0] addr,
                        input logic [7:0] wd, input logic [7:0] exp_rd);
        if (p) begin req_b = 1'b1; we_b = we; addr_b = addr; wdata_b = wd; end
        else   begin req_a = 1'b1; we_a = we; addr_a = addr; wdata_a = wd; end
        tick();
        // ACCESS cycle
        chk("gnt_sel",   {31'd0, p ? gnt_b : gnt_a}, 32'd1);
        chk("gnt_other", {31'd0, p ? gnt_a : gnt_b}, 32'd0);
        chk("acc_busy",  {31'd0, busy}, 32'd1);
        chk("acc_wr",    {31'd0, mem_write}, {31'd0, we});
        chk("acc_rd",    {31'd0, mem_read}, {31'd0, ~we});
        chk("acc_addr",  {24'd0, mem_address}, {24'd0, addr});
        chk("acc_rv",    {30'd0, rvalid_a, rvalid_b}, 32'd0);
        if (we) chk("acc_wdata", {24'd0, mem_write_data}, {24'd0, wd});
        // Drop the request and scramble the fields: must not affect the access.
        if (p) begin req_b = 1'b0; we_b = ~we; addr_b = ~addr; wdata_b = ~wd; end
        else   begin req_a = 1'b0; we_a = ~we; addr_a = ~addr; wdata_a = ~wd; end
        tick();
        chk("post_gnt",  {30'd0, gnt_a, gnt_b}, 32'd0);
        chk("post_strb", {30'd0, mem_write, mem_read}, 32'd0);
        chk("post_addr", {24'd0, mem_address}, {24'd0, addr});
        if (we) begin
            chk("wr_idle_busy", {31'd0, busy}, 32'd0);
            chk("wr_no_rv",     {30'd0, rvalid_a, rvalid_b}, 32'd0);
        end else begin
            chk("rd_busy", {31'd0, busy}, 32'd1);
            chk("rd_rv0",  {30'd0, rvalid_a, rvalid_b}, 32'd0);
            tick();
            chk("rv_busy",  {31'd0, busy}, 32'd0);
            chk("rv_sel",   {31'd0, p ? rvalid_b : rvalid_a}, 32'd1);
            chk("rv_other", {31'd0, p ? rvalid_a : rvalid_b}, 32'd0);
            chk("rdata",    {24'd0, p ? rdata_b : rdata_a}, {24'd0, exp_rd});
        end
    endtask

    logic exp_b [4];

    initial begin
        reset = 1'b1; mem_init = 1'b1;
        req_a = 1'b0; req_b = 1'b0; we_a = 1'b0; we_b = 1'b0;
        addr_a = 8'h00; addr_b = 8'h00; wdata_a = 8'h00; wdata_b = 8'h00;
        repeat (3) tick();
        reset = 1'b0; mem_init = 1'b0;
        tick();

        // Reset state
        chk("rst_gnt",    {30'd0, gnt_a, gnt_b}, 32'd0);
        chk("rst_rvalid", {30'd0, rvalid_a, rvalid_b}, 32'd0);
        chk("rst_strobe", {30'd0, mem_write, mem_read}, 32'd0);
        chk("rst_busy",   {31'd0, busy}, 32'd0);
        chk("rst_rdata",  {16'd0, rdata_a, rdata_b}, 32'd0);
        chk("rst_membus", {16'd0, mem_address, mem_write_data}, 32'd0);

        // Reads straight after reset: addr 0 holds 0xFF, addr 1 holds 0x00
        xfer(1'b0, 1'b0, 8'd0, 8'h00, 8'hFF);
        xfer(1'b0, 1'b0, 8'd1, 8'h00, 8'h00);
        // A writes 0xAA to 10, B reads it back
        xfer(1'b0, 1'b1, 8'd10, 8'hAA, 8'h00);
        chk("idle_hold_wdata", {24'd0, mem_write_data}, 32'hAA);
        xfer(1'b1, 1'b0, 8'd10, 8'h00, 8'hAA);
        chk("rdata_a_held", {24'd0, rdata_a}, 32'h00);
        // A write then A read on a fresh location
        xfer(1'b0, 1'b1, 8'd77, 8'h5C, 8'h00);
        xfer(1'b0, 1'b0, 8'd77, 8'h00, 8'h5C);

        // Both requesting writes continuously for four grants.
        // Last served so far is A, so the round-robin tie goes to B first.
`ifdef DM_ARB_FIXED_PRIO_EN
        exp_b[0] = 1'b0; exp_b[1] = 1'b0; exp_b[2] = 1'b0; exp_b[3] = 1'b0;
`else
        exp_b[0] = 1'b1; exp_b[1] = 1'b0; exp_b[2] = 1'b1; exp_b[3] = 1'b0;
`endif
        req_a = 1'b1; we_a = 1'b1; addr_a = 8'h20; wdata_a = 8'h11;
        req_b = 1'b1; we_b = 1'b1; addr_b = 8'h30; wdata_b = 8'h22;
        for (int g = 0; g < 4; g++) begin
            tick();
            chk("rr_gnt_a", {31'd0, gnt_a}, {31'd0, ~exp_b[g]});
            chk("rr_gnt_b", {31'd0, gnt_b}, {31'd0, exp_b[g]});
            chk("rr_addr",  {24'd0, mem_address}, exp_b[g] ? 32'h30 : 32'h20);
            tick();
        end
        req_a = 1'b0; req_b = 1'b0;
        tick();

        // Reset wipes the memory model too, so re-seed it here.
        // Pointer is fresh from reset: A must win the first tie in both builds.
        reset = 1'b1; mem_init = 1'b1;
        tick();
        reset = 1'b0; mem_init = 1'b0;
        req_a = 1'b1; we_a = 1'b1; addr_a = 8'h40; wdata_a = 8'h01;
        req_b = 1'b1; we_b = 1'b1; addr_b = 8'h41; wdata_b = 8'h02;
        tick();
        chk("tie_after_rst_a", {31'd0, gnt_a}, 32'd1);
        chk("tie_after_rst_b", {31'd0, gnt_b}, 32'd0);
        req_a = 1'b0; req_b = 1'b0;
        tick();
        tick();

        // Reset during RDATA of a port B read discards the read
        req_b = 1'b1; we_b = 1'b0; addr_b = 8'd0;
        tick();
        chk("rr_rst_gnt_b", {31'd0, gnt_b}, 32'd1);
        req_b = 1'b0;
        tick();
        chk("rr_rst_in_rdata", {31'd0, busy}, 32'd1);
        reset = 1'b1;
        tick();
        chk("rst_rd_rvalid", {30'd0, rvalid_a, rvalid_b}, 32'd0);
        chk("rst_rd_busy",   {31'd0, busy}, 32'd0);
        chk("rst_rd_memrd",  {31'd0, mem_read}, 32'd0);
        chk("rst_rd_rdata",  {24'd0, rdata_b}, 32'd0);
        reset = 1'b0;
        tick();
        chk("rst_rd_late_rv", {30'd0, rvalid_a, rvalid_b}, 32'd0);
        chk("rst_rd_late_busy", {31'd0, busy}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
